matmul_result_collector: RTL and testbench
==========================================

MATMUL_RESULT_COLLECTOR -- requirements
Module: matmul_result_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning signed fixed-point word width.
REQ-002 SHALL have parameter FRAC_WIDTH, default 8, meaning fractional bits (Q8.8 at defaults).
REQ-003 SHALL have parameter M, default 4, meaning result rows.
REQ-004 SHALL have parameter N, default 2, meaning result columns.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have ports c_data/c_row/c_col/c_valid/done  input  DATA_WIDTH/clog2(M)/clog2(N)/1/1  result stream from the systolic multiplier.
REQ-008 SHALL have ports bias_data/bias_col/bias_valid  input  DATA_WIDTH/clog2(N)/1  per-column bias write.
REQ-009 SHALL have ports out_data/out_row/out_col  output  DATA_WIDTH/clog2(M)/clog2(N)  biased result element.
REQ-010 SHALL have ports out_valid  output  1, and out_ready  input  1, forming the downstream handshake.
REQ-011 SHALL have ports out_last  output  1  (final element), busy  output  1  (state != IDLE), overrun  output  1  (sticky error).

Function
REQ-012 SHALL implement the states IDLE, COLLECT and DRAIN.
REQ-013 In IDLE, a c_valid beat SHALL write buf[c_row][c_col], set count=1 and enter COLLECT.
REQ-014 In COLLECT, each c_valid beat SHALL write buf[c_row][c_col] and increment count; a repeated address SHALL overwrite the element and still count.
REQ-015 COLLECT SHALL go to DRAIN on the cycle after (c_valid && done) or after count reaches M*N, whichever occurs first.
REQ-016 DRAIN SHALL emit elements in row-major order from (0,0) to (M-1,N-1).
REQ-017 out_valid SHALL first assert one cycle after DRAIN is entered.
REQ-018 out_data/out_row/out_col SHALL be registered and SHALL hold stable while out_valid && !out_ready.
REQ-019 A transfer SHALL occur on out_valid && out_ready; the next element SHALL be presented the following cycle, with no bubble when out_ready is held high.
REQ-020 out_last SHALL be 1 only together with element (M-1,N-1).
REQ-021 After the transfer of the last element, the block SHALL return to IDLE with out_valid=0.
REQ-022 out_data SHALL equal sat(buf[r][c] + bias[c]); the sum SHALL be computed at DATA_WIDTH+1 bits and clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-023 bias writes SHALL be accepted in IDLE and COLLECT and SHALL be ignored in DRAIN.
REQ-024 A c_valid beat in DRAIN SHALL be dropped, buf SHALL remain unchanged, and overrun SHALL be set to 1.
REQ-025 overrun SHALL clear only on reset.
REQ-026 Simultaneous bias_valid and c_valid SHALL both take effect in the same cycle.

Reset
REQ-027 Asserting rst_n low SHALL, at any time including mid-DRAIN, asynchronously force state=IDLE, count=0 and all buf and bias entries to 0.
REQ-028 Asserting rst_n low SHALL force out_data=0, out_row=0, out_col=0, out_valid=0, out_last=0, busy=0 and overrun=0.
REQ-029 After rst_n deasserts, no output SHALL be produced until a new collection completes.

Configuration
REQ-030 With macro MATMUL_COLLECTOR_RELU_EN defined, out_data SHALL be max(0, sat(buf+bias)).
REQ-031 Without MATMUL_COLLECTOR_RELU_EN, out_data SHALL be sat(buf+bias) and negative values SHALL pass through unchanged.

Structure
REQ-032 Package matmul_pkg SHALL hold the collector state encoding, the DATA_WIDTH/FRAC_WIDTH defaults and the saturation limit constants.
REQ-033 The add/saturate/ReLU path SHALL be one combinational sub-module, bias_sat_add, instantiated once.

Verification
REQ-034 Load bias[0]=0x0080, stream buf(0,0)=0x0180 and fill the rest with 0 -> first out_data=0x0200, out_row=0, out_col=0.
REQ-035 Set buf(1,1)=0x7F00 and bias[1]=0x0200 -> element (1,1) out_data=0x7FFF; with 0x8100+0xFE00 -> 0x8000.
REQ-036 Set buf(2,0)=0xFF00 and bias=0 -> out_data=0x0000 with MATMUL_COLLECTOR_RELU_EN, 0xFF00 without it.
REQ-037 Hold out_ready=0 for 5 cycles at element (0,1) -> out_data/out_row/out_col stay stable; 8 transfers in total; out_last only on (3,1); busy=0 the cycle after.
REQ-038 Issue c_valid during DRAIN -> overrun=1, drained values unchanged.
REQ-039 Pull rst_n low during DRAIN at element (2,0) -> out_valid=0 and busy=0 immediately, and a subsequent collection drains the new data correctly.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul result collector: word-format defaults,
// collector state encoding and the saturation limits of the default format.
package matmul_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int FRAC_WIDTH_DEF = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  localparam logic [DATA_WIDTH_DEF-1:0] SAT_MAX_DEF = 16'h7FFF;
  localparam logic [DATA_WIDTH_DEF-1:0] SAT_MIN_DEF = 16'h8000;

endpackage

// File: rtl/bias_sat_add.sv
// Combinational bias add with signed saturation to DATA_WIDTH bits.
// Optional ReLU on the result when MATMUL_COLLECTOR_RELU_EN is defined.
module bias_sat_add
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] y_o
);

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] sat;

  // NOTE: combinational logic uses blocking '=' and assigns every output on every path, so no latch is inferred.
  always_comb begin
    sum = {a_i[DATA_WIDTH-1], a_i} + {b_i[DATA_WIDTH-1], b_i};
    // The two top bits of the widened sum disagree exactly when the true result overflowed.
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
      sat = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      sat = sum[DATA_WIDTH-1:0];
    end
`ifdef MATMUL_COLLECTOR_RELU_EN
    y_o = sat[DATA_WIDTH-1] ? '0 : sat;
`else
    y_o = sat;
`endif
  end

endmodule

// File: rtl/matmul_result_collector.sv
// Collects an MxN result matrix from the systolic array, then drains it row-major
// with per-column bias and saturation. Optional ReLU: define MATMUL_COLLECTOR_RELU_EN.
module matmul_result_collector
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAC_WIDTH = FRAC_WIDTH_DEF,
  parameter int M          = 4,
  parameter int N          = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] c_data,
  input  logic [$clog2(M)-1:0]  c_row,
  input  logic [$clog2(N)-1:0]  c_col,
  input  logic                  c_valid,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] bias_data,
  input  logic [$clog2(N)-1:0]  bias_col,
  input  logic                  bias_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [$clog2(M)-1:0]  out_row,
  output logic [$clog2(N)-1:0]  out_col,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  overrun
);

  localparam int RW    = $clog2(M);
  localparam int CW    = $clog2(N);
  localparam int TOTAL = M * N;
  localparam int NW    = $clog2(TOTAL + 1);

  if (FRAC_WIDTH < 0 || FRAC_WIDTH >= DATA_WIDTH) begin : g_frac_check
    $error("FRAC_WIDTH must lie in [0, DATA_WIDTH-1]");
  end

  logic [1:0]            state_q, state_d;
  logic [NW-1:0]         count_q, count_d;
  logic [RW-1:0]         rd_row_q, rd_row_d;
  logic [CW-1:0]         rd_col_q, rd_col_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [RW-1:0]         out_row_q, out_row_d;
  logic [CW-1:0]         out_col_q, out_col_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  overrun_q, overrun_d;

  logic [DATA_WIDTH-1:0] mat_q  [M][N];
  logic [DATA_WIDTH-1:0] bias_q [N];

  logic                  wr_en, bias_en, xfer, load, finish, rd_at_end;
  logic [DATA_WIDTH-1:0] sum_y;

  assign wr_en     = c_valid && (state_q != ST_DRAIN);
  assign bias_en   = bias_valid && (state_q != ST_DRAIN);
  assign xfer      = out_valid_q && out_ready;
  // Fill the output register on DRAIN entry and after every non-final transfer.
  assign load      = (state_q == ST_DRAIN) && (!out_valid_q || (xfer && !out_last_q));
  assign finish    = (state_q == ST_DRAIN) && xfer && out_last_q;
  assign rd_at_end = (rd_row_q == RW'(M - 1)) && (rd_col_q == CW'(N - 1));

  bias_sat_add #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bias_sat_add (
    .a_i (mat_q[rd_row_q][rd_col_q]),
    .b_i (bias_q[rd_col_q]),
    .y_o (sum_y)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (c_valid) begin
          state_d = ST_COLLECT;
          count_d = NW'(1);
        end
      end
      ST_COLLECT: begin
        if (c_valid) begin
          count_d = count_q + NW'(1);
          if (done || (count_q == NW'(TOTAL - 1))) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (finish) begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    rd_row_d    = rd_row_q;
    rd_col_d    = rd_col_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    overrun_d   = overrun_q | (c_valid && (state_q == ST_DRAIN));
    if (load) begin
      out_data_d  = sum_y;
      out_row_d   = rd_row_q;
      out_col_d   = rd_col_q;
      out_valid_d = 1'b1;
      out_last_d  = rd_at_end;
      // The read pointer wraps to (0,0) after the final element, ready for the next matrix.
      if (rd_col_q == CW'(N - 1)) begin
        rd_col_d = '0;
        rd_row_d = (rd_row_q == RW'(M - 1)) ? '0 : rd_row_q + RW'(1);
      end else begin
        rd_col_d = rd_col_q + CW'(1);
      end
    end else if (finish) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_row_q    <= rd_row_d;
      rd_col_q    <= rd_col_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      overrun_q   <= overrun_d;
    end
  end

  // NOTE: the result and bias stores are flops, not RAM, because reset must clear every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < M; r++) begin
        for (int c = 0; c < N; c++) mat_q[r][c] <= '0;
      end
      for (int c = 0; c < N; c++) bias_q[c] <= '0;
    end else begin
      if (wr_en)   mat_q[c_row][c_col] <= c_data;
      if (bias_en) bias_q[bias_col]    <= bias_data;
    end
  end

  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_matmul_result_collector.sv
// Scoreboard bench for matmul_result_collector at default parameters (Q8.8, 4x2).
// Expected elements are modelled from the driven stimulus and compared as the DUT drains.
module tb_matmul_result_collector;
  import matmul_pkg::*;

  localparam int DW    = 16;
  localparam int M     = 4;
  localparam int N     = 2;
  localparam int TOTAL = M * N;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    row;
    logic [0:0]    col;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] c_data;
  logic [1:0]    c_row;
  logic [0:0]    c_col;
  logic          c_valid;
  logic          done;
  logic [DW-1:0] bias_data;
  logic [0:0]    bias_col;
  logic          bias_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_row;
  logic [0:0]    out_col;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          overrun;

  exp_t          sb[$];
  logic [DW-1:0] m_buf  [M][N];
  logic [DW-1:0] m_bias [N];
  logic [DW-1:0] stim   [M][N];
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  matmul_result_collector #(
    .DATA_WIDTH (DW),
    .FRAC_WIDTH (8),
    .M          (M),
    .N          (N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .c_data     (c_data),
    .c_row      (c_row),
    .c_col      (c_col),
    .c_valid    (c_valid),
    .done       (done),
    .bias_data  (bias_data),
    .bias_col   (bias_col),
    .bias_valid (bias_valid),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .overrun    (overrun)
  );

  function automatic logic [DW-1:0] model_out(logic [DW-1:0] a, logic [DW-1:0] b);
    int s;
    s = $signed(a) + $signed(b);
    if (s > $signed({16'h0000, SAT_MAX_DEF})) s = 32767;
    if (s < -32768) s = -32768;
`ifdef MATMUL_COLLECTOR_RELU_EN
    if (s < 0) s = 0;
`endif
    return s[DW-1:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stim;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) stim[r][c] = '0;
  endtask

  task automatic beat(input int r, input int c, input logic [DW-1:0] d, input logic is_done);
    c_valid = 1'b1;
    c_row   = 2'(r);
    c_col   = 1'(c);
    c_data  = d;
    done    = is_done;
    m_buf[r][c] = d;
    tick();
    c_valid    = 1'b0;
    done       = 1'b0;
    bias_valid = 1'b0;
  endtask

  task automatic write_bias(input int c, input logic [DW-1:0] v);
    bias_valid = 1'b1;
    bias_col   = 1'(c);
    bias_data  = v;
    m_bias[c]  = v;
    tick();
    bias_valid = 1'b0;
  endtask

  task automatic push_expected;
    exp_t e;
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < N; c++) begin
        e.data = model_out(m_buf[r][c], m_bias[c]);
        e.row  = 2'(r);
        e.col  = 1'(c);
        e.last = (r == M - 1) && (c == N - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic check_drain_entry(input string tag);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_drain_entry: out_valid=%b busy=%b, required out_valid=0 busy=1", tag, out_valid, busy);
    end
  endtask

  task automatic stream_all(input string tag);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) beat(r, c, stim[r][c], 1'b0);
    push_expected();
    check_drain_entry(tag);
  endtask

  // Drains one matrix against the scoreboard. Optional stall, overrun injection, or reset at an element index.
  task automatic drain(input string tag, input int stall_at, input int stall_len,
                       input int ovr_at, input int rst_at);
    int   got = 0;
    int   cyc = 0;
    int   stalled = 0;
    bit   seen = 0;
    bit   ovr_done = 0;
    exp_t e;
    out_ready = 1'b1;
    while (got < TOTAL && cyc < 300) begin
      c_valid    = 1'b0;
      bias_valid = 1'b0;
      if (seen || out_valid) begin
        n_cmp++;
        if (out_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL %s_no_bubble: out_valid=%b at element %0d, required 1", tag, out_valid, got);
        end
      end
      if (out_valid === 1'b1) begin
        if (!seen) begin
          seen = 1;
          n_cmp++;
          if (cyc != 1) begin
            n_bad++;
            $display("FAIL %s_first_latency: first out_valid %0d cycles after DRAIN entry, required 1", tag, cyc);
          end
        end
        e = sb[0];
        n_cmp++;
        if ({out_data, out_row, out_col, out_last} !== {e.data, e.row, e.col, e.last}) begin
          n_bad++;
          $display("FAIL %s_elem%0d: data=%h row=%0d col=%0d last=%b, required data=%h row=%0d col=%0d last=%b",
                   tag, got, out_data, out_row, out_col, out_last, e.data, e.row, e.col, e.last);
        end
        if (got == rst_at) begin
          rst_n = 1'b0;
          #1;
          n_cmp++;
          if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || out_data !== '0 ||
              out_row !== '0 || out_col !== '0 || out_last !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_async_reset: valid=%b busy=%b overrun=%b data=%h row=%0d col=%0d last=%b, required all 0",
                     tag, out_valid, busy, overrun, out_data, out_row, out_col, out_last);
          end
          return;
        end
        if (got == stall_at && stalled < stall_len) begin
          out_ready = 1'b0;
          stalled++;
        end else begin
          out_ready = 1'b1;
          void'(sb.pop_front());
          got++;
        end
      end
      if (got == ovr_at && !ovr_done) begin
        ovr_done   = 1;
        c_valid    = 1'b1;
        c_row      = 2'd3;
        c_col      = 1'd1;
        c_data     = 16'h1234;
        bias_valid = 1'b1;
        bias_col   = 1'd1;
        bias_data  = 16'h7000;
      end
      tick();
      cyc++;
    end
    c_valid    = 1'b0;
    bias_valid = 1'b0;
    out_ready  = 1'b1;
    if (got < TOTAL) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: %0d of %0d elements transferred", tag, got, TOTAL);
    end
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_idle_after: out_valid=%b busy=%b, required 0 0", tag, out_valid, busy);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    c_valid = 0; c_data = '0; c_row = '0; c_col = '0; done = 0;
    bias_valid = 0; bias_data = '0; bias_col = '0; out_ready = 1'b1;
    for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) m_buf[r][c] = '0;
    for (int c = 0; c < N; c++) m_bias[c] = '0;
    repeat (3) tick();
    n_cmp++;
    if (out_valid !== 0 || busy !== 0 || overrun !== 0 || out_last !== 0 ||
        out_data !== '0 || out_row !== '0 || out_col !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: valid=%b busy=%b ovr=%b last=%b data=%h row=%0d col=%0d, required all 0",
               out_valid, busy, overrun, out_last, out_data, out_row, out_col);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 0 || busy !== 0) begin
        n_bad++;
        $display("FAIL reset_quiet%0d: out_valid=%b busy=%b, required 0 0", i, out_valid, busy);
      end
    end
  endtask

  task automatic test_basic;
    write_bias(0, 16'h0080);
    write_bias(1, 16'h0000);
    clear_stim();
    stim[0][0] = 16'h0180;
    stream_all("basic");
    drain("basic", -1, 0, -1, -1);
  endtask

  task automatic test_saturation;
    write_bias(0, 16'h0000);
    write_bias(1, 16'h0200);
    clear_stim();
    stim[1][1] = 16'h7F00;
    stim[2][1] = 16'h0100;
    stim[3][0] = 16'hFF80;
    stream_all("sat_pos");
    drain("sat_pos", -1, 0, -1, -1);
    write_bias(1, 16'hFE00);
    stim[1][1] = 16'h8100;
    stream_all("sat_neg");
    drain("sat_neg", -1, 0, -1, -1);
  endtask

  task automatic test_relu;
    write_bias(0, 16'h0000);
    clear_stim();
    stim[2][0] = 16'hFF00;
    stim[0][1] = 16'hFFC0;
    stim[1][1] = 16'h0040;
    // Bias write for column 1 lands in the same cycle as the first result beat.
    bias_valid = 1'b1;
    bias_col   = 1'd1;
    bias_data  = 16'h0020;
    m_bias[1]  = 16'h0020;
    stream_all("relu");
    drain("relu", -1, 0, -1, -1);
  endtask

  task automatic test_back_to_back_backpressure;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) stim[r][c] = 16'($urandom);
    write_bias(0, 16'($urandom));
    write_bias(1, 16'($urandom));
    stream_all("bp");
    drain("bp", 1, 5, -1, -1);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) stim[r][c] = 16'($urandom);
    stream_all("b2b");
    drain("b2b", 3, 2, -1, -1);
  endtask

  task automatic test_overrun;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) stim[r][c] = 16'($urandom_range(0, 16'h0FFF));
    stream_all("ovr");
    drain("ovr", -1, 0, 2, -1);
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL ovr_sticky: overrun=%b, required 1", overrun);
    end
  endtask

  task automatic test_reset_mid_drain;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) stim[r][c] = 16'h0100 + 16'(r * N + c);
    stream_all("rst");
    drain("rst", -1, 0, -1, 4);
    sb.delete();
    for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) m_buf[r][c] = '0;
    for (int c = 0; c < N; c++) m_bias[c] = '0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 0 || busy !== 0) begin
        n_bad++;
        $display("FAIL rst_quiet%0d: out_valid=%b busy=%b, required 0 0", i, out_valid, busy);
      end
    end
    // Early 'done' collection: unwritten elements must read back as cleared by reset.
    write_bias(1, 16'h0040);
    beat(0, 1, 16'h0300, 1'b0);
    beat(3, 0, 16'hFE80, 1'b1);
    push_expected();
    check_drain_entry("post_rst");
    drain("post_rst", -1, 0, -1, -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_relu();
    test_back_to_back_backpressure();
    test_overrun();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
